// File: rtl/fp_div.sv
// Sequential 27-bit floating-point divider (restoring, one quotient bit per cycle).
// Define FP_DIV_RND_EN to add a guard iteration and round half-up instead of truncating.
`timescale 1ns/1ps

module fp_div (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [26:0] num1,
   input  logic [26:0] num2,
   output logic        busy,
   output logic        done,
   output logic [26:0] res,
   output logic        div_by_zero
);

`ifdef FP_DIV_RND_EN
   localparam int N = 21;
`else
   localparam int N = 20;
`endif

   typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        cnt;
   logic [19:0]       rem;
   logic [19:0]       rem_sub;
   logic [18:0]       mb;
   logic [N-1:0]      quo;
   logic signed [9:0] exp_d;
   logic              sign_r;
   logic              special_r;
   logic              dbz_r;
   logic              op_zero;
   logic              rem_ge;
   logic [17:0]       mant;
   logic signed [9:0] exp_n;
   logic [26:0]       res_nxt;
   logic              dbz_nxt;
`ifdef FP_DIV_RND_EN
   logic              guard;
   logic [18:0]       mant_r;
`endif

   assign op_zero = (num1[25:18] == 8'd0) || (num2[25:18] == 8'd0);
   assign rem_ge  = rem >= {1'b0, mb};
   assign rem_sub = rem_ge ? (rem - {1'b0, mb}) : rem;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = op_zero ? NORM : DIV;
         DIV:     if (cnt == 5'(N - 1)) state_nxt = NORM;
         NORM:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Normalisation picks the leading one from the integer or first fraction bit
   always_comb begin
      mant    = quo[N-3:N-20];
      exp_n   = exp_d - 10'sd1;
      res_nxt = 27'h0;
      dbz_nxt = 1'b0;
`ifdef FP_DIV_RND_EN
      guard = quo[0];
      if (quo[N-1]) begin
         mant  = quo[N-2:N-19];
         exp_n = exp_d;
         guard = quo[1];
      end
      mant_r = {1'b0, mant} + {18'd0, guard};
      mant   = mant_r[17:0];
      if (mant_r[18]) exp_n = exp_n + 10'sd1;
`else
      if (quo[N-1]) begin
         mant  = quo[N-2:N-19];
         exp_n = exp_d;
      end
`endif
      if (special_r) begin
         dbz_nxt = dbz_r;
         res_nxt = dbz_r ? {sign_r, 8'hFF, 18'h0} : {sign_r, 26'h0};
      end else if (exp_n <= 10'sd0) begin
         res_nxt = {sign_r, 26'h0};
      end else if (exp_n >= 10'sd255) begin
         res_nxt = {sign_r, 8'hFF, 18'h0};
      end else begin
         res_nxt = {sign_r, exp_n[7:0], mant};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         rem       <= '0;
         mb        <= '0;
         quo       <= '0;
         exp_d     <= '0;
         sign_r    <= 1'b0;
         special_r <= 1'b0;
         dbz_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sign_r    <= num1[26] ^ num2[26];
                  special_r <= op_zero;
                  dbz_r     <= (num2[25:18] == 8'd0);
                  rem       <= {2'b01, num1[17:0]};
                  mb        <= {1'b1, num2[17:0]};
                  exp_d     <= $signed({2'b00, num1[25:18]}) - $signed({2'b00, num2[25:18]}) + 10'sd127;
                  cnt       <= '0;
                  quo       <= '0;
               end
            end
            DIV: begin
               rem <= {rem_sub[18:0], 1'b0};
               quo <= {quo[N-2:0], rem_ge};
               cnt <= cnt + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // busy drops on the same edge that raises done, so a held start is accepted next
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         res         <= 27'h0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) busy <= 1'b1;
         if (state == NORM) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            res         <= res_nxt;
            div_by_zero <= dbz_nxt;
         end
      end
   end

endmodule

// File: doc/fp_div.md
# fp_div

Sequential floating-point divider for the 27-bit simulator number format (1 sign, 8 exponent bias 127, 18 fraction, hidden bit when exponent ≠ 0). It is the inverse of the combinational multiplier in the force/acceleration datapath: it computes `num1 / num2` with a restoring one-bit-per-cycle mantissa divider behind a start/done handshake. The mass-normalisation and `1/r²` stages use it where a full-width combinational divider would not close timing.

## Interface
Parameters:
- none; format fixed at 27 bits.

Ports (`clk` and `reset_n` first):
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request; sampled only in IDLE.
- `num1` in 27: dividend; sampled with `start`.
- `num2` in 27: divisor; sampled with `start`.
- `busy` out 1: high from the edge after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse; `res` is valid in that cycle.
- `res` out 27: quotient; held until the next `done`.
- `div_by_zero` out 1: qualified by `done`; set when the divisor is zero.

## Operation
- Operand fields: sign is bit 26, exponent is [25:18], fraction is [17:0].
- Any operand with exponent 0 is treated as zero. The block supports no denormals.
- Result sign is `num1[26] ^ num2[26]`, in every case including special cases.
- States: IDLE → DIV → NORM → IDLE. Special cases go IDLE → NORM.
- IDLE → DIV when `start` is high, both operands are nonzero.
  - Latch mantissas `ma = {1,num1[17:0]}` and `mb = {1,num2[17:0]}` (19 bits).
  - Latch the exponent difference `ea − eb + 127` as a 10-bit signed value.
  - Clear the iteration counter.
- IDLE → NORM when `start` is high and either operand is zero. Special-case results:
  - Divisor zero (includes 0/0): `res = {s, 8'hFF, 18'h0}`, `div_by_zero = 1`.
  - Otherwise (dividend zero): `res = {s, 26'h0}`.
- DIV, one iteration per cycle (N iterations, N = 20):
  - 20-bit remainder R starts at `ma`.
  - If R ≥ mb: quotient bit is 1 and R ← R − mb. Otherwise the quotient bit is 0.
  - Then R ← R << 1.
  - Quotient bits shift in MSB-first. After N iterations → NORM.
- NORM, with integer quotient bit `q[19]`:
  - If `q[19] = 1`: mantissa = `q[18:1]`, exponent unchanged.
  - Otherwise: mantissa = `q[17:0]`, exponent − 1.
  - Final exponent ≤ 0: flush to `{s, 26'h0}`.
  - Final exponent ≥ 255: saturate to `{s, 8'hFF, 18'h0}`.
  - `div_by_zero` is 0.
- NORM → IDLE, registering `res` and pulsing `done`.
- `start` while `busy` is ignored. Operand changes while `busy` have no effect.

## Timing
- Reset values: state IDLE, `busy = 0`, `done = 0`, `res = 27'h0`, `div_by_zero = 0`, counter 0, remainder 0.
- Edge E0 samples `start`.
- Normal path: `done` is high in the cycle after edge E0+N+1, i.e. 21 edges later (22 with rounding).
- Special path: `done` is high after edge E0+1.
- `busy` rises after E0 and falls in the same edge that raises `done`.
- `start` held high in the `done` cycle is accepted: back-to-back throughput is N+2 cycles.
- Reset asserted mid-DIV aborts the operation: no `done`, all outputs return to reset values immediately, and the next `start` after reset is handled normally.

## Configuration
- `FP_DIV_RND_EN` defined:
  - One extra guard iteration (N = 21).
  - Round half-up on the guard bit.
  - Mantissa carry-out sets the fraction to 0 and increments the exponent, before the overflow check.
- `FP_DIV_RND_EN` undefined: N = 20, truncation, matching the multiplier.

## Test plan
- 6.0/2.0: `num1 = 27'h2060000`, `num2 = 27'h2000000` → `res = 27'h2020000` (3.0), `done` 21 edges after `start`, `div_by_zero = 0`.
- Sign: −6.0/2.0, `num1 = 27'h6060000` → `res = 27'h6020000`.
- 1.0/3.0: `num1 = 27'h1FC0000`, `num2 = 27'h2020000` → `res = 27'h1F55555` in both configurations; latency 22 with `FP_DIV_RND_EN`.
- Divide by zero: 1.0/0 → `res = 27'h3FC0000`, `div_by_zero = 1`, `done` one edge after `start`.
- Dividend zero: 0/5.0 → `res = 27'h0`, `div_by_zero = 0`, latency 1.
- Range and control:
  - Overflow: `27'h3F80000`/`27'h0100000` → `res = 27'h3FC0000`.
  - `start` pulsed during `busy` is ignored.
  - `reset_n` low at iteration 10 → `busy = 0`, no `done`; a subsequent 6.0/2.0 still yields `27'h2020000`.
